// File: rtl/sd_menu_nav.sv
// sd_menu_nav: counts SD directory entries, moves a cursor across pages of ROWS entries
// from debounced, auto-repeating gamepad input, issues a one-cycle ROM-select request
// and continuously paints the cursor glyph into the overlay pixel stream.
// Build option: define SD_MENU_WRAP_EN to make moves wrap around the list ends
// instead of clamping.
module sd_menu_nav #(
    parameter int unsigned FREQ         = 27_000_000,
    parameter int unsigned ROWS         = 20,
    parameter int unsigned MAX_FILES    = 1024,
    parameter int unsigned DEB_MS       = 50,
    parameter int unsigned REP_DELAY_MS = 400,
    parameter int unsigned REP_RATE_MS  = 100,
    parameter int unsigned X0           = 8,
    parameter int unsigned Y0           = 40,
    localparam int unsigned FW          = $clog2(MAX_FILES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    nes_btn,
    input  logic          list_en,
    input  logic          list_done,
    input  logic          busy,
    output logic [FW:0]   total,
    output logic [FW-1:0] cursor,
    output logic [FW-1:0] page_base,
    output logic          page_chg,
    output logic          sel_valid,
    output logic [FW-1:0] sel_file,
    output logic          pix_we,
    output logic [7:0]    scanline,
    output logic [7:0]    cycle,
    output logic [5:0]    color
);

    localparam int unsigned DEB_CYC    = 32'(64'(FREQ) * 64'(DEB_MS) / 64'd1000);
    localparam int unsigned REP_DLY    = 32'(64'(FREQ) * 64'(REP_DELAY_MS) / 64'd1000);
    localparam int unsigned REP_RATE   = 32'(64'(FREQ) * 64'(REP_RATE_MS) / 64'd1000);
    // After a repeat fires, restart the hold counter so it hits REP_DLY again in REP_RATE
    localparam int unsigned REP_RELOAD = REP_DLY - REP_RATE + 1;
    localparam int unsigned DW         = $clog2(DEB_CYC + 2);
    localparam int unsigned RW         = $clog2(REP_DLY + 2);
    localparam int unsigned TW         = FW + 1;
    localparam int unsigned CW         = FW + 2;
    // Right-pointing triangle; bit index = {glyph row, glyph column}
    localparam logic [63:0] GLYPH      = 64'h0103_070F_0F07_0301;

    typedef enum logic [1:0] {StList, StNav, StSel, StEmpty} state_e;

    state_e        state_q, state_d;
    logic          in_list, in_nav, in_empty, paint_en, nav_ok;
    logic [3:0]    dir_q, dir_rise, mv;
    logic          a_q, busy_q, sel_go;
    logic [DW-1:0] deb_q, deb_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [TW-1:0] total_q, total_d;
    logic [FW-1:0] cursor_q, cursor_d, page_base_q, page_d, sel_file_q;
    logic          page_chg_q, sel_valid_q;
    logic [CW-1:0] cur_x, last_x, rows_x, cur_base_x, last_base_x, step_x;
    logic [4:0]    row_q;
    logic [5:0]    dot_q;
    logic          on_row, pix_we_q;
    logic [7:0]    scanline_q, cycle_q;
    logic [5:0]    color_q, paint_color;
    logic          unused_btn;

    assign unused_btn = ^nes_btn[3:1];

    // Highest-priority direction of {R,L,D,U}: U > D > L > R
    function automatic logic [3:0] pick(input logic [3:0] v);
        if (v[0])      return 4'b0001;
        else if (v[1]) return 4'b0010;
        else if (v[2]) return 4'b0100;
        else if (v[3]) return 4'b1000;
        else           return 4'b0000;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StList;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StList:  if (list_done) state_d = (total_d == '0) ? StEmpty : StNav;
            StNav:   if (sel_go) state_d = StSel;
            StSel:   if (busy_q && !busy) state_d = StNav;
            default: state_d = state_q;
        endcase
    end

    // State-decoded controls
    always_comb begin
        in_list  = 1'b0;
        in_nav   = 1'b0;
        in_empty = 1'b0;
        unique case (state_q)
            StList:  in_list = 1'b1;
            StNav:   in_nav = 1'b1;
            StEmpty: in_empty = 1'b1;
            default: ;
        endcase
        paint_en = !in_list;
        nav_ok   = in_nav && !busy;
    end

    // Press edges, debounce lockout and auto-repeat timing
    always_comb begin
        dir_rise = nes_btn[7:4] & ~dir_q;
        sel_go   = nav_ok && nes_btn[0] && !a_q;
        mv       = 4'b0000;
        deb_d    = (deb_q != '0) ? deb_q - DW'(1) : '0;
        rep_d    = '0;
        if (nav_ok && !sel_go) begin
            if (|dir_rise) begin
                rep_d = RW'(1);
                if (deb_q == '0) begin
                    mv    = pick(dir_rise);
                    deb_d = DW'(DEB_CYC);
                end
            end else if (|nes_btn[7:4]) begin
                if (rep_q >= RW'(REP_DLY)) begin
                    rep_d = RW'(REP_RELOAD);
                    if (deb_q == '0) mv = pick(nes_btn[7:4]);
                end else begin
                    rep_d = rep_q + RW'(1);
                end
            end
        end
        total_d = (in_list && list_en && total_q < TW'(MAX_FILES)) ? total_q + TW'(1) : total_q;
    end

    // Cursor move arithmetic, two spare bits so cursor+ROWS cannot overflow
    always_comb begin
        cur_x       = CW'(cursor_q);
        last_x      = CW'(total_q) - CW'(1);
        rows_x      = CW'(ROWS);
        cur_base_x  = (cur_x / rows_x) * rows_x;
        last_base_x = (last_x / rows_x) * rows_x;
        step_x      = cur_x;
        unique case (mv)
`ifdef SD_MENU_WRAP_EN
            4'b0001: step_x = (cur_x == '0) ? last_x : cur_x - CW'(1);
            4'b0010: step_x = (cur_x >= last_x) ? '0 : cur_x + CW'(1);
            4'b0100: step_x = (cur_x < rows_x) ? last_base_x : cur_x - rows_x;
            4'b1000: step_x = (cur_base_x == last_base_x) ? '0 :
                              (cur_x + rows_x > last_x) ? last_x : cur_x + rows_x;
`else
            4'b0001: step_x = (cur_x == '0) ? '0 : cur_x - CW'(1);
            4'b0010: step_x = (cur_x >= last_x) ? last_x : cur_x + CW'(1);
            4'b0100: step_x = (cur_x < rows_x) ? '0 : cur_x - rows_x;
            4'b1000: step_x = (cur_x + rows_x > last_x) ? last_x : cur_x + rows_x;
`endif
            default: step_x = cur_x;
        endcase
        cursor_d = FW'(step_x);
        page_d   = FW'(cur_base_x);
    end

    // Navigation datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q       <= '0;
            a_q         <= 1'b0;
            busy_q      <= 1'b0;
            total_q     <= '0;
            cursor_q    <= '0;
            page_base_q <= '0;
            page_chg_q  <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_file_q  <= '0;
            deb_q       <= '0;
            rep_q       <= '0;
        end else begin
            dir_q       <= nes_btn[7:4];
            a_q         <= nes_btn[0];
            busy_q      <= busy;
            total_q     <= total_d;
            cursor_q    <= cursor_d;
            page_base_q <= page_d;
            page_chg_q  <= (page_d != page_base_q);
            sel_valid_q <= sel_go;
            if (sel_go) sel_file_q <= cursor_q;
            deb_q       <= deb_d;
            rep_q       <= rep_d;
        end
    end

    // Glyph lookup for the pixel under the painter counter
    always_comb begin
        on_row      = ((cursor_q - page_base_q) == FW'(row_q));
        paint_color = (!in_empty && on_row && GLYPH[dot_q]) ? 6'd55 : 6'd13;
    end

    // Painter sweep: one 8x8 cell per menu row, cursor drawn and old one erased
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q      <= '0;
            dot_q      <= '0;
            pix_we_q   <= 1'b0;
            scanline_q <= '0;
            cycle_q    <= '0;
            color_q    <= 6'd13;
        end else if (paint_en) begin
            dot_q <= dot_q + 6'd1;
            if (dot_q == 6'd63) row_q <= (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
            pix_we_q   <= 1'b1;
            scanline_q <= 8'(Y0) + {row_q, 3'b000} + {5'b00000, dot_q[5:3]};
            cycle_q    <= 8'(X0) + {5'b00000, dot_q[2:0]};
            color_q    <= paint_color;
        end else begin
            pix_we_q <= 1'b0;
        end
    end

    assign total     = total_q;
    assign cursor    = cursor_q;
    assign page_base = page_base_q;
    assign page_chg  = page_chg_q;
    assign sel_valid = sel_valid_q;
    assign sel_file  = sel_file_q;
    assign pix_we    = pix_we_q;
    assign scanline  = scanline_q;
    assign cycle     = cycle_q;
    assign color     = color_q;

endmodule

// File: tb/tb_sd_menu_nav.sv
// tb_sd_menu_nav: directed table plus hand sequences for sd_menu_nav with
// FREQ=1000, ROWS=4, DEB_MS=2, REP_DELAY_MS=5, REP_RATE_MS=2.
module tb_sd_menu_nav;

    localparam int unsigned FW = 10;
    localparam logic [7:0] BR = 8'h80, BL = 8'h40, BD = 8'h20, BU = 8'h10, BA = 8'h01;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    nes_btn;
    logic          list_en, list_done, busy;
    logic [FW:0]   total;
    logic [FW-1:0] cursor, page_base, sel_file;
    logic          page_chg, sel_valid, pix_we;
    logic [7:0]    scanline, cycle;
    logic [5:0]    color;

    int n_chk = 0;
    int n_pass = 0;
    int chg_cnt, sel_cnt;
    logic [FW-1:0] sel_seen;

    typedef struct {
        logic [7:0] btn;
        logic       bz;
        int         cur;
        int         base;
        int         chg;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    sd_menu_nav #(
        .FREQ(1000), .ROWS(4), .MAX_FILES(1024), .DEB_MS(2),
        .REP_DELAY_MS(5), .REP_RATE_MS(2), .X0(8), .Y0(40)
    ) dut (
        .clk(clk), .reset(reset), .nes_btn(nes_btn), .list_en(list_en),
        .list_done(list_done), .busy(busy), .total(total), .cursor(cursor),
        .page_base(page_base), .page_chg(page_chg), .sel_valid(sel_valid),
        .sel_file(sel_file), .pix_we(pix_we), .scanline(scanline), .cycle(cycle),
        .color(color)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] b, input logic bz);
        nes_btn = b;
        busy    = bz;
        tick();
        if (page_chg) chg_cnt++;
        if (sel_valid) begin
            sel_cnt++;
            sel_seen = sel_file;
        end
    endtask

    // One-cycle press followed by a quiet window long enough to clear the lockout
    task automatic press(input logic [7:0] b, input logic bz);
        chg_cnt = 0;
        sel_cnt = 0;
        step(b, bz);
        repeat (5) step(8'h00, bz);
    endtask

    int we, bad, hits, r0, r0_bad, sy, sx, prow, gy, lim, expc;
    logic [15:0] mask;
    logic [FW-1:0] prev;

    initial begin
        nes_btn = '0; list_en = 0; list_done = 0; busy = 0; reset = 1;
        sel_seen = '0; chg_cnt = 0; sel_cnt = 0;
        vecs[0] = '{BR, 1'b0, 4, 4, 1};
        vecs[1] = '{BR, 1'b0, 8, 8, 1};
        vecs[2] = '{BR, 1'b0, 9, 8, 0};
        vecs[3] = '{BL, 1'b0, 5, 4, 1};
        vecs[4] = '{BU, 1'b0, 4, 4, 0};
        vecs[5] = '{BL, 1'b0, 0, 0, 1};
        vecs[6] = '{BD, 1'b1, 0, 0, 0};

        repeat (2) tick();
        check("rst total", total, 0);
        check("rst cursor", cursor, 0);
        check("rst page_base", page_base, 0);
        check("rst page_chg", page_chg, 0);
        check("rst sel_valid", sel_valid, 0);
        check("rst pix_we", pix_we, 0);
        check("rst scanline", scanline, 0);
        check("rst cycle", cycle, 0);
        check("rst color", color, 13);
        reset = 0;
        tick();

        // Nine spaced entries, the tenth coincides with list_done
        for (int i = 0; i < 9; i++) begin
            list_en = 1; tick();
            list_en = 0; tick();
        end
        list_en = 1; list_done = 1; tick();
        list_en = 0; list_done = 0;
        check("list total", total, 10);
        check("list pix_we idle", pix_we, 0);
        repeat (3) tick();
        check("nav pix_we", pix_we, 1);

        for (int i = 0; i < 7; i++) begin
            press(vecs[i].btn, vecs[i].bz);
            check($sformatf("vec%0d cursor", i), cursor, vecs[i].cur);
            check($sformatf("vec%0d page_base", i), page_base, vecs[i].base);
            check($sformatf("vec%0d page_chg", i), chg_cnt, vecs[i].chg);
        end

`ifdef SD_MENU_WRAP_EN
        press(BU, 0);
        check("wrap U cursor", cursor, 9);
        check("wrap U page_base", page_base, 8);
        check("wrap U page_chg", chg_cnt, 1);
        press(BR, 0);
        check("wrap R cursor", cursor, 0);
        check("wrap R page_chg", chg_cnt, 1);
        press(BL, 0);
        check("wrap L cursor", cursor, 8);
        check("wrap L page_base", page_base, 8);
        press(BD, 0);
        press(BD, 0);
        check("wrap D cursor", cursor, 0);
        check("wrap D page_base", page_base, 0);
`else
        press(BU, 0);
        check("clamp U cursor", cursor, 0);
        check("clamp U page_chg", chg_cnt, 0);
`endif

        // Second D edge lands while the lockout still has one clock left
        step(BD, 0); step(8'h00, 0); step(BD, 0);
        repeat (4) step(8'h00, 0);
        check("debounce cursor", cursor, 1);
        press(BU, 0);
        check("back to 0", cursor, 0);

        // Hold D for 11 clocks; record which clocks moved the cursor
        mask = '0;
        prev = cursor;
        for (int i = 0; i < 11; i++) begin
            nes_btn = BD;
            tick();
            if (cursor != prev) mask[i] = 1'b1;
            prev = cursor;
        end
        nes_btn = '0;
        tick();
        check("repeat move mask", mask, 16'h02A1);
        check("repeat cursor", cursor, 4);
        check("repeat page_base", page_base, 4);
        repeat (3) tick();

        chg_cnt = 0; sel_cnt = 0;
        step(BA, 0);
        repeat (4) step(8'h00, 0);
        check("select pulses", sel_cnt, 1);
        check("select file", sel_seen, 4);
        press(BD, 0);
        check("sel frozen cursor", cursor, 4);
        check("sel no repeat pulse", sel_cnt, 0);
        press(BD, 1);
        check("busy D ignored", cursor, 4);
        repeat (2) step(8'h00, 0);
        press(BD, 0);
        check("nav after busy", cursor, 5);
        check("nav after busy base", page_base, 4);

        // One full sweep of 4 rows * 64 dots
        we = 0; bad = 0; hits = 0; r0 = 0; r0_bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pix_we) begin
                we++;
                sy = int'(scanline) - 40;
                sx = int'(cycle) - 8;
                if (sy < 0 || sy >= 32 || sx < 0 || sx > 7) begin
                    bad++;
                end else begin
                    prow = sy / 8;
                    gy   = sy % 8;
                    lim  = (gy < 4) ? gy : 7 - gy;
                    expc = (prow == 1 && sx <= lim) ? 55 : 13;
                    if (int'(color) != expc) bad++;
                    if (prow == 0) begin
                        r0++;
                        if (color != 6'd13) r0_bad++;
                    end
                end
                if (color == 6'd55) hits++;
            end
        end
        check("paint we count", we, 256);
        check("paint bad pixels", bad, 0);
        check("paint glyph pixels", hits, 20);
        check("paint row0 count", r0, 64);
        check("paint row0 non-bg", r0_bad, 0);

        // Asynchronous reset in the middle of an auto-repeat hold
        nes_btn = BD;
        repeat (6) tick();
        #2 reset = 1;
        #1;
        check("midrst cursor", cursor, 0);
        check("midrst pix_we", pix_we, 0);
        check("midrst total", total, 0);
        check("midrst page_base", page_base, 0);
        nes_btn = '0;
        tick();
        reset = 0;
        tick();

        list_en = 1;
        repeat (1030) tick();
        list_en = 0;
        tick();
        check("total saturates", total, 1024);
        reset = 1; tick();
        reset = 0; tick();

        list_done = 1; tick();
        list_done = 0; tick();
        chg_cnt = 0; sel_cnt = 0;
        step(BA, 0);
        repeat (4) step(8'h00, 0);
        check("empty no select", sel_cnt, 0);
        we = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (pix_we) we++;
            if (color != 6'd13) bad++;
        end
        check("empty paint we", we, 64);
        check("empty paint bg only", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
